// File: rtl/pipe_ctrl_unit.sv
// Pipeline control for the IF/ID boundary: turns hazard-unit stall/flush
// requests into PC/IF-ID enables and an ID/EX bubble, and keeps event statistics.
module pipe_ctrl_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned MAX_STALL = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall_Req,
  input  logic        Flush_Req,
  input  logic [31:0] If_Pc,
  input  logic [31:0] If_Instr,
  output logic        Pc_Write,
  output logic        IfId_Write,
  output logic        IdEx_Bubble,
  output logic [31:0] IfId_Pc,
  output logic [31:0] IfId_Instr,
  output logic        IfId_Valid,
  output logic [15:0] Stall_Cnt,
  output logic [15:0] Flush_Cnt,
  output logic        Stall_Err
);

  localparam int unsigned RW = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_STALL);

  typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_eff_stall;
  logic [RW-1:0]   r_run;
  logic [RW-1:0]   w_run_inc;
  logic [31:0]     r_ifid_pc;
  logic [31:0]     r_ifid_instr;
  logic            r_ifid_valid;
  logic [15:0]     r_stall_cnt;
  logic [15:0]     r_flush_cnt;
  logic            r_stall_err;

  // A stall request arriving while ID holds a flush bubble has nothing to protect.
  assign w_eff_stall = Stall_Req & ~Flush_Req & (r_state != S_FLUSH);
  assign w_run_inc   = (r_run == RUN_MAX) ? r_run : r_run + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = S_RUN;
    if (Flush_Req)        w_next = S_FLUSH;
    else if (w_eff_stall) w_next = S_STALL;
  end

  always_comb begin
    Pc_Write    = ~w_eff_stall;
    IfId_Write  = ~w_eff_stall;
    IdEx_Bubble = w_eff_stall | Flush_Req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_stall_err  <= 1'b0;
      r_run        <= '0;
    end else if (Flush_Req) begin
      r_ifid_pc    <= If_Pc;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      r_run        <= '0;
      if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 16'd1;
    end else if (w_eff_stall) begin
      r_run <= w_run_inc;
      if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_run_inc == RUN_MAX) r_stall_err <= 1'b1;
    end else begin
      r_ifid_pc    <= If_Pc;
      r_ifid_instr <= If_Instr;
      r_ifid_valid <= 1'b1;
      r_run        <= '0;
    end
  end

  assign IfId_Pc    = r_ifid_pc;
  assign IfId_Instr = r_ifid_instr;
  assign IfId_Valid = r_ifid_valid;
  assign Stall_Cnt  = r_stall_cnt;
  assign Flush_Cnt  = r_flush_cnt;
  assign Stall_Err  = r_stall_err;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: abstract event model checked every cycle,
// plus literal expectations on the key scenarios.
module tb_pipe_ctrl_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int MAXS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall_Req, Flush_Req;
  logic [31:0] If_Pc, If_Instr;
  logic        Pc_Write, IfId_Write, IdEx_Bubble;
  logic [31:0] IfId_Pc, IfId_Instr;
  logic        IfId_Valid;
  logic [15:0] Stall_Cnt, Flush_Cnt;
  logic        Stall_Err;

  pipe_ctrl_unit #(.NOP_INSTR(NOP), .MAX_STALL(MAXS)) dut (
    .clk(clk), .rst(rst), .Stall_Req(Stall_Req), .Flush_Req(Flush_Req),
    .If_Pc(If_Pc), .If_Instr(If_Instr), .Pc_Write(Pc_Write),
    .IfId_Write(IfId_Write), .IdEx_Bubble(IdEx_Bubble), .IfId_Pc(IfId_Pc),
    .IfId_Instr(IfId_Instr), .IfId_Valid(IfId_Valid), .Stall_Cnt(Stall_Cnt),
    .Flush_Cnt(Flush_Cnt), .Stall_Err(Stall_Err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    else n_pass++;
  endfunction

  // Event-level model: what IF/ID holds, how many events happened, how long the current stall streak is.
  logic [31:0] m_pc, m_instr;
  bit          m_valid, m_err, m_shadow, m_live;
  int          m_sc, m_fc, m_streak;

  initial m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0; m_instr = NOP; m_valid = 0; m_err = 0;
      m_shadow = 0; m_sc = 0; m_fc = 0; m_streak = 0; m_live = 1'b1;
    end else if (m_live) begin
      if (Flush_Req) begin
        m_pc = If_Pc; m_instr = NOP; m_valid = 0;
        m_fc = (m_fc < 65535) ? m_fc + 1 : 65535;
        m_streak = 0; m_shadow = 1;
      end else if (Stall_Req && !m_shadow) begin
        m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
        m_streak = m_streak + 1;
        if (m_streak >= MAXS) m_err = 1;
        m_shadow = 0;
      end else begin
        m_pc = If_Pc; m_instr = If_Instr; m_valid = 1;
        m_streak = 0; m_shadow = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      automatic bit e_stall = Stall_Req && !Flush_Req && !m_shadow;
      chk("Pc_Write",    32'(Pc_Write),    32'(!e_stall));
      chk("IfId_Write",  32'(IfId_Write),  32'(!e_stall));
      chk("IdEx_Bubble", 32'(IdEx_Bubble), 32'(e_stall || Flush_Req));
      chk("IfId_Pc",     IfId_Pc,          m_pc);
      chk("IfId_Instr",  IfId_Instr,       m_instr);
      chk("IfId_Valid",  32'(IfId_Valid),  32'(m_valid));
      chk("Stall_Cnt",   32'(Stall_Cnt),   32'(m_sc));
      chk("Flush_Cnt",   32'(Flush_Cnt),   32'(m_fc));
      chk("Stall_Err",   32'(Stall_Err),   32'(m_err));
    end
  end

  task automatic drive(bit s, bit f, logic [31:0] pc, logic [31:0] ins);
    Stall_Req = s; Flush_Req = f; If_Pc = pc; If_Instr = ins;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1; Stall_Req = 0; Flush_Req = 0; If_Pc = 32'h0; If_Instr = 32'h0;
    tick(); tick();
    rst = 0;
    chk("rst_pc",    IfId_Pc, 32'h0);
    chk("rst_instr", IfId_Instr, NOP);
    chk("rst_valid", 32'(IfId_Valid), 32'h0);
    chk("rst_err",   32'(Stall_Err), 32'h0);

    drive(0, 0, 32'h100, 32'h8C41_0004);
    chk("run_pcw", 32'(Pc_Write), 32'h1);
    tick();
    chk("run_pc",    IfId_Pc, 32'h100);
    chk("run_valid", 32'(IfId_Valid), 32'h1);

    drive(0, 0, 32'h104, 32'h0022_1820); tick();
    drive(1, 0, 32'h108, 32'hDEAD_BEEF);
    chk("lu_pcw",    32'(Pc_Write), 32'h0);
    chk("lu_bubble", 32'(IdEx_Bubble), 32'h1);
    tick();
    chk("lu_hold",  IfId_Instr, 32'h0022_1820);
    chk("lu_scnt",  32'(Stall_Cnt), 32'h1);
    chk("lu_err",   32'(Stall_Err), 32'h0);
    drive(0, 0, 32'h108, 32'hDEAD_BEEF); tick();
    chk("lu_resume", IfId_Pc, 32'h108);

    drive(1, 1, 32'h200, 32'h1234_5678);
    chk("both_pcw", 32'(Pc_Write), 32'h1);
    tick();
    chk("both_instr", IfId_Instr, NOP);
    chk("both_valid", 32'(IfId_Valid), 32'h0);
    chk("both_fcnt",  32'(Flush_Cnt), 32'h1);
    chk("both_scnt",  32'(Stall_Cnt), 32'h1);

    drive(1, 0, 32'h204, 32'h1111_1111);
    chk("shadow_pcw", 32'(Pc_Write), 32'h1);
    tick();
    chk("shadow_pc", IfId_Pc, 32'h204);
    drive(1, 0, 32'h208, 32'h2222_2222);
    chk("back_run_pcw", 32'(Pc_Write), 32'h0);
    tick();

    drive(0, 1, 32'h300, 32'h3333_3333); tick();
    chk("stf_instr", IfId_Instr, NOP);
    drive(0, 0, 32'h304, 32'h4444_4444); tick();

    drive(1, 0, 32'h400, 32'h5555_5555); tick(); tick();
    drive(0, 0, 32'h400, 32'h5555_5555); tick();
    drive(1, 0, 32'h404, 32'h6666_6666); tick(); tick();
    chk("wd_no_err", 32'(Stall_Err), 32'h0);
    tick();
    chk("wd_err", 32'(Stall_Err), 32'h1);
    drive(0, 0, 32'h404, 32'h6666_6666); tick();
    chk("wd_sticky", 32'(Stall_Err), 32'h1);

    drive(1, 0, 32'h500, 32'h7777_7777); tick();
    rst = 1; drive(1, 1, 32'h504, 32'h8888_8888); tick();
    rst = 0;
    chk("mrst_err",   32'(Stall_Err), 32'h0);
    chk("mrst_scnt",  32'(Stall_Cnt), 32'h0);
    chk("mrst_fcnt",  32'(Flush_Cnt), 32'h0);
    chk("mrst_instr", IfId_Instr, NOP);
    chk("mrst_pc",    IfId_Pc, 32'h0);

    drive(0, 1, 32'h600, 32'h9999_9999);
    for (int i = 0; i < 65535; i++) tick();
    chk("sat_reach", 32'(Flush_Cnt), 32'hFFFF);
    tick();
    chk("sat_hold", 32'(Flush_Cnt), 32'hFFFF);
    drive(0, 0, 32'h604, 32'hAAAA_AAAA); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0000: instruction word injected into IF/ID on flush.
REQ-002 Parameter MAX_STALL, default 3: consecutive-stall-cycle limit before the error flag sets.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 Stall_Req  input  1  stall request from the hazard detection unit (load-use).
REQ-006 Flush_Req  input  1  flush request from the hazard detection unit (taken branch / branch-after-load).
REQ-007 If_Pc  input  32  PC of the instruction in IF.
REQ-008 If_Instr  input  32  instruction word fetched in IF.
REQ-009 Pc_Write  output  1  PC register enable, combinational.
REQ-010 IfId_Write  output  1  IF/ID load enable, combinational, exported for observation.
REQ-011 IdEx_Bubble  output  1  forces ID/EX control signals to zero this cycle, combinational.
REQ-012 IfId_Pc  output  32  registered IF/ID PC.
REQ-013 IfId_Instr  output  32  registered IF/ID instruction.
REQ-014 IfId_Valid  output  1  registered; 0 means IF/ID holds a bubble.
REQ-015 Stall_Cnt  output  16  total stall cycles, saturating.
REQ-016 Flush_Cnt  output  16  total flush events, saturating.
REQ-017 Stall_Err  output  1  sticky; set when a stall run reaches MAX_STALL cycles.

Function
REQ-018 FSM states: RUN, STALL, FLUSH; encoding is free.
REQ-019 Effective stall: eff_stall = Stall_Req & ~Flush_Req & (state != FLUSH).
REQ-020 Flush has priority over stall in every state.
REQ-021 Pc_Write = ~eff_stall; IfId_Write = ~eff_stall; IdEx_Bubble = eff_stall | Flush_Req.
REQ-022 Flush_Req=1, any state: IfId_Instr<=NOP_INSTR, IfId_Pc<=If_Pc, IfId_Valid<=0, next=FLUSH, Flush_Cnt+1 saturating at 16'hFFFF.
REQ-023 eff_stall=1: IF/ID registers hold, next=STALL, Stall_Cnt+1 saturating at 16'hFFFF, run counter+1.
REQ-024 Neither flush nor effective stall: IfId_Pc<=If_Pc, IfId_Instr<=If_Instr, IfId_Valid<=1, next=RUN, run counter<=0.
REQ-025 FLUSH lasts one cycle unless Flush_Req is reasserted; Stall_Req is ignored in FLUSH because ID holds a bubble.
REQ-026 Run counter: internal, width ceil(log2(MAX_STALL+1)), saturating; cleared on any non-stall cycle.
REQ-027 Stall_Err<=1 on the edge where the run counter reaches MAX_STALL; cleared only by rst.
REQ-028 Stall followed by flush on the next cycle: the held IF/ID content is replaced by NOP_INSTR and the run counter clears.
REQ-029 Latency: a new IF/ID value is visible one cycle after the accepting edge; control enables respond in the same cycle as the requests.

Reset
REQ-030 rst=1 at an edge: state=RUN, IfId_Pc=0, IfId_Instr=NOP_INSTR, IfId_Valid=0, Stall_Cnt=0, Flush_Cnt=0, Stall_Err=0, run counter=0.
REQ-031 rst has priority over Flush_Req and Stall_Req; reset mid-stall or mid-flush discards the operation without counting it.
REQ-032 Combinational outputs follow REQ-021 during reset; downstream logic gates them with rst.

Verification
REQ-033 Free run: If_Pc=0x100, If_Instr=0x8C410004, no requests -> next cycle IfId_Pc=0x100, IfId_Valid=1, Pc_Write=1.
REQ-034 Load-use: Stall_Req=1 for 1 cycle with IfId_Instr=0x00221820 -> Pc_Write=0, IdEx_Bubble=1, IF/ID unchanged, Stall_Cnt=1, Stall_Err=0.
REQ-035 Simultaneous requests: Stall_Req=1 and Flush_Req=1 -> Pc_Write=1, IfId_Instr=NOP_INSTR, IfId_Valid=0, Flush_Cnt=1, Stall_Cnt=0.
REQ-036 Flush shadow: Flush_Req cycle N, Stall_Req=1 at N+1 -> no stall at N+1, Pc_Write=1, state returns to RUN.
REQ-037 Watchdog: Stall_Req held 3 cycles (MAX_STALL=3) -> Stall_Err=1 after the third edge and stays 1 after Stall_Req drops; rst clears it.
REQ-038 Saturation/reset: preload Flush_Cnt to 16'hFFFF, flush once -> stays 16'hFFFF; assert rst during STALL -> all REQ-030 values next cycle.
